// File: rtl/dmem_mmio_if.sv
// Data-memory request bus between the core MEM stage and dmem_mmio.
// Master drives the request; slave returns registered load data and error pulse.
interface dmem_mmio_if;
    logic [31:0] dmem_addr_i;
    logic        dmem_we_i;
    logic        dmem_re_i;
    logic [31:0] dmem_wdata_i;
    logic [3:0]  dmem_wmask_i;
    logic [31:0] dmem_rdata_o;
    logic        bus_err_o;

    modport master (
        output dmem_addr_i, dmem_we_i, dmem_re_i, dmem_wdata_i, dmem_wmask_i,
        input  dmem_rdata_o, bus_err_o
    );

    modport slave (
        input  dmem_addr_i, dmem_we_i, dmem_re_i, dmem_wdata_i, dmem_wmask_i,
        output dmem_rdata_o, bus_err_o
    );
endinterface

// File: rtl/dmem_mmio.sv
// Data-side memory subsystem: byte-masked RAM, buffered 8N1 UART TX, 64-bit mtime.
// Loads return one cycle after the request; no stall, rejected accesses pulse bus_err_o.
module dmem_mmio #(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_DIV    = 868
) (
    input  logic        clk,
    input  logic        arst,
    dmem_mmio_if.slave  bus,
    output logic        uart_tx_o
);
    localparam int AW  = $clog2(RAM_WORDS);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(CLK_DIV);

    localparam logic [29:0] A_TXDATA = 30'h0400_0000;
    localparam logic [29:0] A_STATUS = 30'h0400_0001;
    localparam logic [29:0] A_MT_LO  = 30'h0400_0002;
    localparam logic [29:0] A_MT_HI  = 30'h0400_0003;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

    logic [29:0]   waddr;
    logic          sel_ram, sel_tx, sel_status, sel_lo, sel_hi, unmapped;
    logic [AW-1:0] ram_idx;
    logic [31:0]   ram [RAM_WORDS];
    logic [31:0]   rd_val;
    logic          err_d;

    logic [63:0]   mtime;
    logic [31:0]   mtime_shadow;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [FAW-1:0] wr_ptr, rd_ptr;
    logic [FAW:0]  count;
    logic          full, empty, push_req, push_ok, pop, busy;

    tx_state_t     state, state_nx;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    tx_shift;
    logic          bit_end;

    // Address decode on the word address; the byte offset is ignored.
    assign waddr      = bus.dmem_addr_i[31:2];
    assign ram_idx    = waddr[AW-1:0];
    assign sel_ram    = waddr < 30'(RAM_WORDS);
    assign sel_tx     = waddr == A_TXDATA;
    assign sel_status = waddr == A_STATUS;
    assign sel_lo     = waddr == A_MT_LO;
    assign sel_hi     = waddr == A_MT_HI;
    assign unmapped   = !(sel_ram || sel_tx || sel_status || sel_lo || sel_hi);

    assign full     = count == (FAW+1)'(FIFO_DEPTH);
    assign empty    = count == '0;
    assign busy     = (state != S_IDLE) || !empty;
    assign push_req = bus.dmem_we_i && sel_tx && bus.dmem_wmask_i[0];
    assign push_ok  = push_req && (!full || pop);
    assign bit_end  = baud_cnt == CW'(CLK_DIV - 1);

    always_comb begin
        rd_val = '0;
        if (sel_ram)         rd_val = ram[ram_idx];
        else if (sel_status) rd_val = {30'd0, busy, full};
        else if (sel_lo)     rd_val = mtime[31:0];
        else if (sel_hi)     rd_val = mtime_shadow;
    end

    always_comb begin
        err_d = ((bus.dmem_re_i || bus.dmem_we_i) && unmapped)
              || (bus.dmem_we_i && sel_status)
              || (push_req && !push_ok);
    end

    // RAM and FIFO storage carry no reset so they map onto plain memories.
    always_ff @(posedge clk) begin
        if (bus.dmem_we_i && sel_ram) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.dmem_wmask_i[b]) ram[ram_idx][8*b +: 8] <= bus.dmem_wdata_i[8*b +: 8];
            end
        end
        if (push_ok) fifo_mem[wr_ptr] <= bus.dmem_wdata_i[7:0];
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            bus.dmem_rdata_o <= '0;
            bus.bus_err_o    <= 1'b0;
            mtime            <= '0;
            mtime_shadow     <= '0;
        end else begin
            bus.bus_err_o <= err_d;
            if (bus.dmem_re_i) bus.dmem_rdata_o <= rd_val;
            if (bus.dmem_re_i && sel_lo) mtime_shadow <= mtime[63:32];
            // A software write takes priority over the free-running increment.
            if (bus.dmem_we_i && sel_lo)      mtime <= {mtime[63:32], bus.dmem_wdata_i};
            else if (bus.dmem_we_i && sel_hi) mtime <= {bus.dmem_wdata_i, mtime[31:0]};
            else                              mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_shift <= '0;
        end else if (pop) begin
            tx_shift <= fifo_mem[rd_ptr];
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else if (state == S_IDLE) begin
            baud_cnt <= '0;
        end else if (bit_end) begin
            baud_cnt <= '0;
            if (state == S_DATA) bit_idx <= bit_idx + 3'd1;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (!empty) state_nx = S_START;
            S_START: if (bit_end) state_nx = S_DATA;
            S_DATA:  if (bit_end && bit_idx == 3'd7) state_nx = S_STOP;
            S_STOP:  if (bit_end) state_nx = empty ? S_IDLE : S_START;
            default: state_nx = S_IDLE;
        endcase
    end

    // Line level decodes straight from state so reset forces idle-high at once.
    always_comb begin
        uart_tx_o = 1'b1;
        pop       = 1'b0;
        case (state)
            S_IDLE:  pop = !empty;
            S_START: uart_tx_o = 1'b0;
            S_DATA:  uart_tx_o = tx_shift[bit_idx];
            S_STOP:  pop = bit_end && !empty;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: RAM lanes, decode errors, mtime coherence, UART framing, FIFO overflow, reset abort.
module tb_dmem_mmio;
    localparam int CLK_DIV = 4;
    localparam logic [31:0] TXD  = 32'h1000_0000;
    localparam logic [31:0] STAT = 32'h1000_0004;
    localparam logic [31:0] MLO  = 32'h1000_0008;
    localparam logic [31:0] MHI  = 32'h1000_000C;

    logic clk = 1'b0;
    logic arst = 1'b1;
    logic uart_tx;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [8:0] rx_q [$];

    dmem_mmio_if bus ();

    dmem_mmio #(.RAM_WORDS(1024), .FIFO_DEPTH(8), .CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .arst      (arst),
        .bus       (bus),
        .uart_tx_o (uart_tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the request is sampled at the following posedge
    // and the task returns at the next negedge with the registered response visible.
    task automatic acc(input logic we, input logic re, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
        bus.dmem_we_i    = we;
        bus.dmem_re_i    = re;
        bus.dmem_addr_i  = a;
        bus.dmem_wdata_i = d;
        bus.dmem_wmask_i = m;
        @(negedge clk);
        bus.dmem_we_i = 1'b0;
        bus.dmem_re_i = 1'b0;
    endtask

    // Serial receiver: samples the first cycle of each bit; frames hit by reset are discarded.
    initial begin : uart_mon
        logic [7:0] b;
        logic       ab;
        forever begin
            @(negedge clk);
            if (!arst && uart_tx === 1'b0) begin
                ab = 1'b0;
                b  = '0;
                for (int k = 1; k <= 9*CLK_DIV; k++) begin
                    @(negedge clk);
                    if (arst) ab = 1'b1;
                    if (k % CLK_DIV == 0 && k < 9*CLK_DIV) b[k/CLK_DIV-1] = uart_tx;
                end
                if (!ab) rx_q.push_back({uart_tx, b});
            end
        end
    end

    initial begin
        logic [7:0] v;
        int n;
        int t;
        bus.dmem_we_i = 1'b0; bus.dmem_re_i = 1'b0; bus.dmem_addr_i = '0;
        bus.dmem_wdata_i = '0; bus.dmem_wmask_i = '0;

        repeat (2) @(negedge clk);
        chk("rst_rdata", bus.dmem_rdata_o, 0);
        chk("rst_tx", uart_tx, 1);
        chk("rst_err", bus.bus_err_o, 0);
        arst = 1'b0;
        acc(0, 1, STAT, 0, 0);
        chk("rst_status", bus.dmem_rdata_o, 0);

        // RAM lanes, hold, read-first, top word
        acc(1, 0, 32'h10, 32'hAABB_CCDD, 4'b1111);
        chk("ram_wr_err", bus.bus_err_o, 0);
        acc(1, 0, 32'h10, 32'h0000_1100, 4'b0010);
        acc(0, 1, 32'h10, 0, 0);
        chk("ram_lane", bus.dmem_rdata_o, 32'hAABB_11DD);
        @(negedge clk);
        chk("ram_hold", bus.dmem_rdata_o, 32'hAABB_11DD);
        acc(1, 1, 32'h10, 32'h1234_5678, 4'b1111);
        chk("ram_rd_first", bus.dmem_rdata_o, 32'hAABB_11DD);
        acc(0, 1, 32'h10, 0, 0);
        chk("ram_new", bus.dmem_rdata_o, 32'h1234_5678);
        acc(1, 0, 32'hFFC, 32'h1122_3344, 4'b1111);
        acc(1, 0, 32'hFFC, 32'hCAFE_F00D, 4'b1001);
        acc(0, 1, 32'hFFE, 0, 0);
        chk("ram_top_mask", bus.dmem_rdata_o, 32'hCA22_330D);
        chk("ram_top_err", bus.bus_err_o, 0);

        // Unmapped and illegal accesses
        acc(1, 0, 32'h2000_0000, 32'hDEAD_BEEF, 4'b1111);
        chk("unm_wr_err", bus.bus_err_o, 1);
        @(negedge clk);
        chk("unm_err_pulse", bus.bus_err_o, 0);
        acc(0, 1, 32'h2000_0000, 0, 0);
        chk("unm_rd_data", bus.dmem_rdata_o, 0);
        chk("unm_rd_err", bus.bus_err_o, 1);
        acc(0, 1, 32'h1000, 0, 0);
        chk("past_ram_err", bus.bus_err_o, 1);
        acc(0, 1, 32'h10, 0, 0);
        chk("ram_intact", bus.dmem_rdata_o, 32'h1234_5678);
        chk("ram_intact_err", bus.bus_err_o, 0);
        acc(1, 0, STAT, 32'hFFFF_FFFF, 4'b1111);
        chk("status_wr_err", bus.bus_err_o, 1);
        acc(1, 0, TXD, 32'hFF, 4'b1110);
        chk("txd_nomask_err", bus.bus_err_o, 0);
        acc(0, 1, STAT, 0, 0);
        chk("txd_nomask_idle", bus.dmem_rdata_o, 0);

        // mtime: LO write, three idle cycles, then coherent LO/HI pair
        acc(1, 0, MHI, 32'h0, 4'b0000);
        acc(1, 0, MLO, 32'hFFFF_FFFD, 4'b0000);
        repeat (3) @(negedge clk);
        acc(0, 1, MLO, 0, 0);
        chk("mtime_lo", bus.dmem_rdata_o, 32'h0);
        acc(0, 1, MHI, 0, 0);
        chk("mtime_hi", bus.dmem_rdata_o, 32'h1);

        // Single 0x55 frame, checked cycle by cycle
        rx_q.delete();
        acc(1, 0, TXD, 32'h55, 4'b0001);
        chk("tx_idle_after_push", uart_tx, 1);
        n = 1;
        while (uart_tx !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("tx_start_cycle", n, 2);
        v = 8'h55;
        for (int k = 0; k < 10*CLK_DIV; k++) begin
            if (k < CLK_DIV)         chk("tx_bit", uart_tx, 0);
            else if (k < 9*CLK_DIV)  chk("tx_bit", uart_tx, v[(k-CLK_DIV)/CLK_DIV]);
            else                     chk("tx_bit", uart_tx, 1);
            if (k == 20) begin
                acc(0, 1, STAT, 0, 0);
                chk("tx_busy", bus.dmem_rdata_o[1], 1);
            end else begin
                @(negedge clk);
            end
        end
        acc(0, 1, STAT, 0, 0);
        chk("tx_done_status", bus.dmem_rdata_o, 0);
        chk("tx_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("tx_rx_byte", rx_q[0], 9'h155);

        // FIFO overflow: ten back-to-back pushes, tenth dropped
        rx_q.delete();
        for (int i = 1; i <= 10; i++) begin
            acc(1, 0, TXD, 32'(i), 4'b0001);
            chk("fifo_push_err", bus.bus_err_o, (i == 10) ? 1 : 0);
        end
        acc(0, 1, STAT, 0, 0);
        chk("fifo_full_status", bus.dmem_rdata_o, 3);
        chk("fifo_err_once", bus.bus_err_o, 0);
        t = 0;
        while (rx_q.size() < 9 && t < 600) begin
            @(negedge clk);
            t++;
        end
        chk("fifo_rx_count", rx_q.size(), 9);
        for (int i = 0; i < 9; i++) begin
            if (i < rx_q.size()) chk("fifo_rx_byte", rx_q[i], {1'b1, 8'(i + 1)});
        end
        repeat (50) @(negedge clk);
        chk("fifo_no_extra", rx_q.size(), 9);

        // Reset during the DATA phase of 0xA5 (bit1 is low)
        rx_q.delete();
        acc(1, 0, TXD, 32'hA5, 4'b0001);
        repeat (10) @(negedge clk);
        chk("rst_mid_tx_low", uart_tx, 0);
        arst = 1'b1;
        #1;
        chk("rst_tx_immediate", uart_tx, 1);
        @(negedge clk);
        arst = 1'b0;
        acc(0, 1, STAT, 0, 0);
        chk("rst_status_clear", bus.dmem_rdata_o, 0);
        acc(0, 1, MLO, 0, 0);
        chk("rst_mtime_lo", bus.dmem_rdata_o, 1);
        repeat (60) @(negedge clk);
        chk("rst_no_frame", rx_q.size(), 0);
        chk("rst_tx_idle", uart_tx, 1);
        acc(0, 1, 32'h10, 0, 0);
        chk("rst_ram_kept", bus.dmem_rdata_o, 32'h1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
